dmem_responder: RTL and testbench

- Data-memory responder for the single-cycle/multi-cycle RISC-V core.
- Sits on the memory side of the memRead/memWrite/memtoReg path driven by the core's control decode.
- Accepts one load or store request, applies RV32I access size and sign rules, and inserts a programmable number of wait states.
- Returns load data with a one-cycle done pulse, and drives stall back to the PC/pipeline while busy.

---
 rtl/dmem_responder_pkg.sv | 38 +++
 rtl/dmem_lane_align.sv | 96 +++++++++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes,
// FSM state encoding and the access-size decode helper.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    // Reserved load codes read a full word; stores with funct3[2] set act as SW.
    function automatic size_t access_size(input logic [2:0] f3, input logic is_store);
        size_t sz;
        if (is_store && f3[2]) begin
            sz = SZ_WORD;
        end else begin
            case (f3)
                F3_B, F3_BU: sz = SZ_BYTE;
                F3_H, F3_HU: sz = SZ_HALF;
                default:     sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / data replication and
// load shift + sign/zero extension. Misalignment detection under DMEM_MISALIGN_CHECK_EN.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    size_t       size_s;
    logic        mis_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        signed_s;

    assign size_s   = access_size(funct3, is_store);
    assign signed_s = ~funct3[2];

`ifdef DMEM_MISALIGN_CHECK_EN
    // Halfwords need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        case (size_s)
            SZ_HALF: mis_s = lane[0];
            SZ_WORD: mis_s = (lane != 2'b00);
            default: mis_s = 1'b0;
        endcase
    end
`else
    assign mis_s = 1'b0;
`endif

    assign misaligned = mis_s;

    // Select the addressed byte and halfword from the read word.
    always_comb begin
        case (lane)
            2'b00:   byte_s = rword[7:0];
            2'b01:   byte_s = rword[15:8];
            2'b10:   byte_s = rword[23:16];
            2'b11:   byte_s = rword[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rword[31:16];
        end else begin
            half_s = rword[15:0];
        end
    end

    // Load extension; a misaligned load returns zero.
    always_comb begin
        rdata_ext = 32'h0000_0000;
        if (mis_s) begin
            rdata_ext = 32'h0000_0000;
        end else begin
            case (size_s)
                SZ_BYTE: rdata_ext = {{24{signed_s & byte_s[7]}}, byte_s};
                SZ_HALF: rdata_ext = {{16{signed_s & half_s[15]}}, half_s};
                default: rdata_ext = rword;
            endcase
        end
    end

    // Store lane enables and replicated write data; a misaligned store writes nothing.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (size_s)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
        if (mis_s) begin
            byte_en = 4'b0000;
        end else begin
            byte_en = byte_en;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// RV32I data-memory responder with programmable wait states and one-cycle done.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall,
    output logic              misaligned
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];

    state_t             state_r, state_next_s;
    logic [3:0]         cnt_r, cnt_next_s;
    logic [IDX_W+1:0]   addr_r;
    logic [2:0]         funct3_r;
    logic [31:0]        wdata_r;
    logic               store_r;
    logic               done_r;
    logic               mis_r;
    logic [31:0]        rdata_r;

    logic               req_s;
    logic               capture_s;
    logic               enter_resp_s;
    logic [IDX_W+1:0]   acc_addr_s;
    logic [2:0]         acc_funct3_s;
    logic [31:0]        acc_wdata_s;
    logic               acc_store_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [3:0]         byte_en_s;
    logic [31:0]        wdata_rep_s;
    logic [31:0]        rdata_ext_s;
    logic               mis_s;
    logic               unused_addr_s;

    logic [31:0]        mem [DEPTH];

    assign req_s         = mem_read | mem_write;
    assign capture_s     = (state_r == ST_IDLE) & req_s;
    assign unused_addr_s = ^addr[ADDR_W-1:IDX_W+2];

    // With zero wait states RESP is entered straight from IDLE, so the live
    // request drives the datapath in IDLE and the captured copy afterwards.
    assign acc_addr_s   = (state_r == ST_IDLE) ? addr[IDX_W+1:0] : addr_r;
    assign acc_funct3_s = (state_r == ST_IDLE) ? funct3 : funct3_r;
    assign acc_wdata_s  = (state_r == ST_IDLE) ? wdata : wdata_r;
    assign acc_store_s  = (state_r == ST_IDLE) ? mem_write : store_r;
    assign acc_idx_s    = acc_addr_s[IDX_W+1:2];

    dmem_lane_align u_align (
        .funct3     (acc_funct3_s),
        .lane       (acc_addr_s[1:0]),
        .is_store   (acc_store_s),
        .wdata      (acc_wdata_s),
        .rword      (mem[acc_idx_s]),
        .byte_en    (byte_en_s),
        .wdata_rep  (wdata_rep_s),
        .rdata_ext  (rdata_ext_s),
        .misaligned (mis_s)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    cnt_next_s = WAIT_LOAD;
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_RESP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign enter_resp_s = (state_next_s == ST_RESP);

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request capture; store wins when both read and write are asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= '0;
            funct3_r <= 3'b000;
            wdata_r  <= 32'h0000_0000;
            store_r  <= 1'b0;
        end else if (capture_s) begin
            addr_r   <= addr[IDX_W+1:0];
            funct3_r <= funct3;
            wdata_r  <= wdata;
            store_r  <= mem_write;
        end
    end

    // Store commit on the edge entering RESP; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (enter_resp_s && acc_store_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    mem[acc_idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
                end
            end
        end
    end

    // Response registers: done/misaligned pulse in RESP, rdata updates on loads only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r  <= 1'b0;
            mis_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            done_r <= enter_resp_s;
            mis_r  <= enter_resp_s & mis_s;
            if (enter_resp_s && !acc_store_s) begin
                rdata_r <= rdata_ext_s;
            end
        end
    end

    assign rdata = rdata_r;
    assign done  = done_r;
    assign stall = req_s & ~done_r;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = mis_r;
`else
    logic unused_mis_s;
    assign unused_mis_s = mis_r;
    assign misaligned   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, WAIT_CYCLES=2).
module tb_dmem_responder;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3    = 3'b000;
    logic [31:0] addr      = 32'h0;
    logic [31:0] wdata     = 32'h0;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        misaligned;

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic        stall_done_q;
    logic [3:0]  stall_hist;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .stall      (stall),
        .misaligned (misaligned)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access: request driven after a falling edge, sampled 1 ns later each cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int c;
        c = 0;
        stall_hist = 4'b0000;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        while (!done && c < 20) begin
            if (c < 4) stall_hist[c] = stall;
            @(negedge clk);
            #1;
            c++;
        end
        lat_q        = c;
        rdata_q      = rdata;
        mis_q        = misaligned;
        stall_done_q = stall;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        access(1'b0, 1'b1, f3, a, wd);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a);
        access(1'b1, 1'b0, f3, a, 32'h0);
    endtask

    initial begin
        logic saw_done;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_done", {31'b0, done}, 32'h0);
        check_eq("rst_stall", {31'b0, stall}, 32'h0);
        check_eq("rst_mis", {31'b0, misaligned}, 32'h0);

        store(3'b010, 32'h10, 32'hDEADBEEF);
        check_eq("sw_lat", lat_q, 32'd3);
        check_eq("sw_stall_0_2", {28'b0, stall_hist[2:0]}, 32'h7);
        check_eq("sw_stall_done", {31'b0, stall_done_q}, 32'h0);
        check_eq("sw_rdata_kept", rdata_q, 32'h0);

        load(3'b010, 32'h10);
        check_eq("lw_lat", lat_q, 32'd3);
        check_eq("lw_stall_0_2", {28'b0, stall_hist[2:0]}, 32'h7);
        check_eq("lw_data", rdata_q, 32'hDEADBEEF);
        check_eq("lw_mis", {31'b0, mis_q}, 32'h0);

        store(3'b000, 32'h13, 32'h00000080);
        load(3'b000, 32'h13);
        check_eq("lb_sext", rdata_q, 32'hFFFFFF80);
        load(3'b100, 32'h13);
        check_eq("lbu_zext", rdata_q, 32'h00000080);
        load(3'b010, 32'h10);
        check_eq("lw_after_sb", rdata_q, 32'h80ADBEEF);
        load(3'b000, 32'h11);
        check_eq("lb_lane1", rdata_q, 32'hFFFFFFBE);

        store(3'b010, 32'h20, 32'hCAFE5678);
        store(3'b001, 32'h22, 32'h00001234);
        load(3'b101, 32'h22);
        check_eq("lhu_hi", rdata_q, 32'h00001234);
        load(3'b001, 32'h20);
        check_eq("lh_lo_sext", rdata_q, 32'h00005678);
        load(3'b010, 32'h20);
        check_eq("lw_after_sh", rdata_q, 32'h12345678);

        access(1'b1, 1'b1, 3'b010, 32'h40, 32'h00000055);
        check_eq("both_lat", lat_q, 32'd3);
        check_eq("both_rdata_kept", rdata_q, 32'h12345678);
        load(3'b010, 32'h40);
        check_eq("both_store_won", rdata_q, 32'h00000055);

        store(3'b010, 32'h1004, 32'hA5A5A5A5);
        load(3'b010, 32'h4);
        check_eq("alias_word1", rdata_q, 32'hA5A5A5A5);

        store(3'b110, 32'h30, 32'h11223344);
        load(3'b111, 32'h30);
        check_eq("reserved_word", rdata_q, 32'h11223344);

        store(3'b010, 32'h50, 32'h0BADF00D);
        load(3'b010, 32'h50);
        check_eq("pre_rst_lw", rdata_q, 32'h0BADF00D);

        @(negedge clk);
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h50; wdata = 32'h11;
        @(negedge clk);
        rst_n = 1'b0; mem_write = 1'b0;
        #1;
        check_eq("midrst_rdata", rdata, 32'h0);
        saw_done = done;
        repeat (2) begin
            @(negedge clk);
            #1;
            saw_done = saw_done | done;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            saw_done = saw_done | done;
        end
        check_eq("midrst_no_done", {31'b0, saw_done}, 32'h0);
        load(3'b010, 32'h50);
        check_eq("midrst_no_commit", rdata_q, 32'h0BADF00D);

`ifdef DMEM_MISALIGN_CHECK_EN
        load(3'b010, 32'h22);
        check_eq("mis_lw_lat", lat_q, 32'd3);
        check_eq("mis_lw_flag", {31'b0, mis_q}, 32'h1);
        check_eq("mis_lw_data", rdata_q, 32'h0);
        store(3'b010, 32'h21, 32'hFFFFFFFF);
        check_eq("mis_sw_flag", {31'b0, mis_q}, 32'h1);
        load(3'b010, 32'h20);
        check_eq("mis_sw_nowrite", rdata_q, 32'h12345678);
        check_eq("mis_clear", {31'b0, mis_q}, 32'h0);
`else
        load(3'b010, 32'h22);
        check_eq("align_lw_flag", {31'b0, mis_q}, 32'h0);
        check_eq("align_lw_data", rdata_q, 32'h12345678);
        store(3'b010, 32'h21, 32'hFFFFFFFF);
        load(3'b010, 32'h20);
        check_eq("align_sw_data", rdata_q, 32'hFFFFFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
